// File: rtl/ae_pkg.sv
// Shared encodings for the ae_exec_core slice: op fields, activations, FSM states
// and the fixed-point 1.0 helper.
package ae_pkg;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_MUL  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RELU  = 2'b01;
  localparam logic [1:0] ACT_DRELU = 2'b10;
  localparam logic [1:0] ACT_SIG   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef struct packed {
    logic [1:0] act;
    logic [1:0] alu;
  } op_t;

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic logic [63:0] fx_one(input int unsigned frac_w);
    return 64'(1) << frac_w;
  endfunction

endpackage

// File: rtl/ae_exec_core_act.sv
// ae_act_unit: combinational activation stage (none / ReLU / ReLU' / sigmoid).
// The sigmoid LUT exists only when AE_SIGMOID_EN is defined; otherwise sigmoid flags an error.
module ae_act_unit
  import ae_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned LUT_AW = 6
) (
  input  logic [1:0]        act_i,
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] y_c,
  output logic              act_err_c
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(fx_one(FRAC_W));

  if (FRAC_W < 1 || FRAC_W > DATA_W - 2 || LUT_AW < 1) begin : g_param_check
    $error("ae_act_unit: illegal FRAC_W/LUT_AW");
  end

  logic x_neg_c;
  logic x_pos_c;
  assign x_neg_c = x_i[DATA_W-1];
  assign x_pos_c = !x_i[DATA_W-1] && (|x_i);

`ifdef AE_SIGMOID_EN
  localparam int unsigned LUT_N = 1 << LUT_AW;
  localparam int unsigned EXT_W = DATA_W + 3 + LUT_AW;
  localparam int          ONE_I = 1 << FRAC_W;

  function automatic real exp_r(input real t);
    real r;
    real term;
    real s;
    r    = t / 16.0;
    term = 1.0;
    s    = 1.0;
    for (int k = 1; k < 15; k++) begin
      term = term * r / real'(k);
      s    = s + term;
    end
    for (int k = 0; k < 4; k++) s = s * s;
    return s;
  endfunction

  // Each entry holds sigmoid of the lower edge of its bin in [-4.0, 4.0).
  function automatic logic [DATA_W-1:0] sig_entry(input int unsigned idx);
    real x;
    real v;
    x = -4.0 + 8.0 * real'(idx) / real'(LUT_N);
    v = 1.0 / (1.0 + exp_r(-x));
    return DATA_W'($rtoi(v * real'(ONE_I) + 0.5));
  endfunction

  logic [DATA_W-1:0] lut_c [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign lut_c[g] = sig_entry(g);
  end

  logic signed [EXT_W-1:0] x_ext_c;
  logic signed [EXT_W-1:0] four_c;
  logic        [EXT_W-1:0] off_c;
  logic        [EXT_W-1:0] scaled_c;
  logic        [LUT_AW-1:0] idx_c;

  // Bin index = floor((x + 4.0) * 2^LUT_AW / 8.0), kept integer-only.
  always_comb begin
    x_ext_c  = {{(EXT_W-DATA_W){x_i[DATA_W-1]}}, x_i};
    four_c   = EXT_W'(4) << FRAC_W;
    off_c    = x_ext_c + four_c;
    scaled_c = off_c << LUT_AW;
    idx_c    = LUT_AW'(scaled_c >> (FRAC_W + 3));
  end
`endif

  always_comb begin
    y_c       = x_i;
    act_err_c = 1'b0;
    case (act_i)
      ACT_RELU:  y_c = x_neg_c ? '0 : x_i;
      ACT_DRELU: y_c = x_pos_c ? ONE : '0;
      ACT_SIG: begin
`ifdef AE_SIGMOID_EN
        if (x_ext_c <= -four_c)     y_c = '0;
        else if (x_ext_c >= four_c) y_c = ONE;
        else                        y_c = lut_c[idx_c];
`else
        act_err_c = 1'b1;
`endif
      end
      default: y_c = x_i;
    endcase
  end

endmodule

// File: rtl/ae_exec_core.sv
// ae_exec_core: 4-stage (IDLE/READ/EXEC/WRITE) fixed-point ALU + activation over a local memory.
// Sigmoid support is selected by the AE_SIGMOID_EN macro (see ae_act_unit).
module ae_exec_core
  import ae_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LUT_AW = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3+3*ADDR_W:0]   instr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic [DATA_W-1:0]     host_rdata
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned INSTR_W = 4 + 3 * ADDR_W;
  localparam int unsigned WW      = 2 * DATA_W;

  logic [1:0]        state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic              accept_c;
  logic [DATA_W:0]   sum_c, diff_c;
  logic [WW-1:0]     a_ext_c, b_ext_c, prod_c, prod_sh_c;
  logic [DATA_W-1:0] alu_c, act_y_c;
  logic              act_err_c;

  // Clamp a 2*DATA_W two's-complement value into DATA_W.
  function automatic logic [DATA_W-1:0] sat_w(input logic [WW-1:0] v);
    logic [DATA_W:0] hi;
    hi = v[WW-1:DATA_W-1];
    if ((&hi) || !(|hi)) return v[DATA_W-1:0];
    else if (v[WW-1])    return {1'b1, {(DATA_W-1){1'b0}}};
    else                 return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  always_comb begin
    sum_c     = {opa_q[DATA_W-1], opa_q} + {opb_q[DATA_W-1], opb_q};
    diff_c    = {opa_q[DATA_W-1], opa_q} - {opb_q[DATA_W-1], opb_q};
    a_ext_c   = {{DATA_W{opa_q[DATA_W-1]}}, opa_q};
    b_ext_c   = {{DATA_W{opb_q[DATA_W-1]}}, opb_q};
    prod_c    = a_ext_c * b_ext_c;
    prod_sh_c = $signed(prod_c) >>> FRAC_W;
    case (op_q.alu)
      ALU_ADD:  alu_c = sat_w({{(DATA_W-1){sum_c[DATA_W]}}, sum_c});
      ALU_SUB:  alu_c = sat_w({{(DATA_W-1){diff_c[DATA_W]}}, diff_c});
      ALU_MUL:  alu_c = sat_w(prod_sh_c);
      default:  alu_c = opa_q;
    endcase
  end

  ae_act_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .LUT_AW (LUT_AW)
  ) u_act (
    .act_i     (op_q.act),
    .x_i       (alu_c),
    .y_c       (act_y_c),
    .act_err_c (act_err_c)
  );

  assign accept_c = instr_valid && ready_q;

  // Next-state and datapath control; memory has a single write port shared by host and WRITE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    err_d       = err_q;
    done_d      = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = host_addr;
    mem_wdata_c = host_wdata;
    case (state_q)
      ST_IDLE: begin
        mem_we_c = host_we;
        if (accept_c) begin
          state_d = ST_READ;
          op_d    = op_t'(instr[INSTR_W-1 -: 4]);
          src_a_d = instr[3*ADDR_W-1 -: ADDR_W];
          src_b_d = instr[2*ADDR_W-1 -: ADDR_W];
          dst_d   = instr[ADDR_W-1:0];
        end
      end
      ST_READ: begin
        opa_d   = mem_q[src_a_q];
        opb_d   = mem_q[src_b_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = act_y_c;
        err_d   = err_q | act_err_c;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = dst_q;
        mem_wdata_c = res_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= mem_q[host_addr];
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign host_rdata  = rdata_q;

endmodule

// File: tb/tb_ae_exec_core.sv
// Directed self-checking bench for ae_exec_core (DATA_W=16, FRAC_W=8, ADDR_W=4).
module tb_ae_exec_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        busy, done, err;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_MUL      = 4'b0010;
  localparam logic [3:0] OP_PASS     = 4'b0011;
  localparam logic [3:0] OP_SUB_RELU = 4'b0101;
  localparam logic [3:0] OP_PASS_RELU = 4'b0111;
  localparam logic [3:0] OP_PASS_DRELU = 4'b1011;
  localparam logic [3:0] OP_PASS_SIG = 4'b1111;

  ae_exec_core dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata)
  );

  always #5 clock = ~clock;

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clock);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clock);
    host_addr = a;
    @(negedge clock);
    d = host_rdata;
  endtask

  // Issue one instruction and watch a bounded window; lat = cycles from accept edge to done.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, output int lat, output int ndone);
    @(negedge clock);
    instr = {op, a, b, d};
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    lat = -1;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic test_reset;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++; if (host_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", host_rdata); end
  endtask

  task automatic test_add;
    int lat, nd; logic [15:0] r;
    host_write(4'd1, 16'h0180);
    host_write(4'd2, 16'h0200);
    run_instr(OP_ADD, 4'd1, 4'd2, 4'd3, lat, nd);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL add_done_pulses: got %0d expected 1", nd); end
    host_read(4'd3, r);
    n_tests++; if (r !== 16'h0380) begin n_fail++; $display("FAIL add_result: got %h expected 0380", r); end
  endtask

  task automatic test_saturate;
    int lat, nd; logic [15:0] r;
    host_write(4'd4, 16'h7F00);
    host_write(4'd5, 16'h7F00);
    run_instr(OP_ADD, 4'd4, 4'd5, 4'd6, lat, nd);
    host_read(4'd6, r);
    n_tests++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL add_sat: got %h expected 7fff", r); end
    host_write(4'd4, 16'h0180);
    host_write(4'd5, 16'hFE00);
    run_instr(OP_MUL, 4'd4, 4'd5, 4'd6, lat, nd);
    host_read(4'd6, r);
    n_tests++; if (r !== 16'hFD00) begin n_fail++; $display("FAIL mul_neg: got %h expected fd00", r); end
    host_write(4'd4, 16'h8000);
    host_write(4'd5, 16'h0100);
    run_instr(OP_SUB, 4'd4, 4'd5, 4'd6, lat, nd);
    host_read(4'd6, r);
    n_tests++; if (r !== 16'h8000) begin n_fail++; $display("FAIL sub_sat: got %h expected 8000", r); end
    host_write(4'd4, 16'h4000);
    host_write(4'd5, 16'h0400);
    run_instr(OP_MUL, 4'd4, 4'd5, 4'd6, lat, nd);
    host_read(4'd6, r);
    n_tests++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL mul_sat: got %h expected 7fff", r); end
  endtask

  task automatic test_activation;
    int lat, nd; logic [15:0] r;
    host_write(4'd7, 16'h0100);
    host_write(4'd8, 16'h0300);
    run_instr(OP_SUB_RELU, 4'd7, 4'd8, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0000) begin n_fail++; $display("FAIL relu_neg: got %h expected 0000", r); end
    run_instr(OP_SUB_RELU, 4'd8, 4'd7, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0200) begin n_fail++; $display("FAIL relu_pos: got %h expected 0200", r); end
    host_write(4'd7, 16'h0001);
    run_instr(OP_PASS_DRELU, 4'd7, 4'd0, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0100) begin n_fail++; $display("FAIL drelu_pos: got %h expected 0100", r); end
    host_write(4'd7, 16'h0000);
    run_instr(OP_PASS_DRELU, 4'd7, 4'd0, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0000) begin n_fail++; $display("FAIL drelu_zero: got %h expected 0000", r); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b expected 0", err); end
  endtask

  task automatic test_sigmoid;
    int lat, nd; logic [15:0] r;
`ifdef AE_SIGMOID_EN
    host_write(4'd7, 16'h0000);
    run_instr(OP_PASS_SIG, 4'd7, 4'd0, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0080) begin n_fail++; $display("FAIL sig_zero: got %h expected 0080", r); end
    host_write(4'd7, 16'h0500);
    run_instr(OP_PASS_SIG, 4'd7, 4'd0, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0100) begin n_fail++; $display("FAIL sig_high: got %h expected 0100", r); end
    host_write(4'd7, 16'hFB00);
    run_instr(OP_PASS_SIG, 4'd7, 4'd0, 4'd9, lat, nd);
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0000) begin n_fail++; $display("FAIL sig_low: got %h expected 0000", r); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL sig_err: got %b expected 0", err); end
`else
    host_write(4'd7, 16'h0500);
    run_instr(OP_PASS_SIG, 4'd7, 4'd0, 4'd9, lat, nd);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sig_off_done: got %0d expected 3", lat); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL sig_off_err: got %b expected 1", err); end
    host_read(4'd9, r);
    n_tests++; if (r !== 16'h0500) begin n_fail++; $display("FAIL sig_off_raw: got %h expected 0500", r); end
`endif
  endtask

  task automatic test_back_to_back;
    int acc[$]; logic [15:0] r;
    host_write(4'd10, 16'h0010);
    host_write(4'd11, 16'h0020);
    @(negedge clock);
    instr = {OP_ADD, 4'd10, 4'd11, 4'd12};
    instr_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (instr_ready) acc.push_back(c);
      @(negedge clock);
    end
    instr_valid = 1'b0;
    repeat (5) @(negedge clock);
    n_tests++; if (acc.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", acc.size()); end
    if (acc.size() == 4) begin
      n_tests++; if (acc[1] - acc[0] !== 4) begin n_fail++; $display("FAIL b2b_gap0: got %0d expected 4", acc[1] - acc[0]); end
      n_tests++; if (acc[3] - acc[2] !== 4) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected 4", acc[3] - acc[2]); end
    end
    host_read(4'd12, r);
    n_tests++; if (r !== 16'h0030) begin n_fail++; $display("FAIL b2b_result: got %h expected 0030", r); end
  endtask

  task automatic test_host_we_busy;
    logic [15:0] r;
    host_write(4'd14, 16'h1234);
    @(negedge clock);
    instr = {OP_ADD, 4'd10, 4'd11, 4'd15};
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    host_we = 1'b1; host_addr = 4'd14; host_wdata = 16'hDEAD;
    repeat (3) @(negedge clock);
    host_we = 1'b0;
    host_read(4'd14, r);
    n_tests++; if (r !== 16'h1234) begin n_fail++; $display("FAIL we_busy_dropped: got %h expected 1234", r); end
    host_read(4'd15, r);
    n_tests++; if (r !== 16'h0030) begin n_fail++; $display("FAIL we_busy_result: got %h expected 0030", r); end
  endtask

  task automatic test_coincident_and_alias;
    int lat, nd; logic [15:0] r;
    host_write(4'd0, 16'h0011);
    @(negedge clock);
    instr = {OP_PASS, 4'd0, 4'd0, 4'd13};
    instr_valid = 1'b1;
    host_we = 1'b1; host_addr = 4'd0; host_wdata = 16'h0222;
    @(negedge clock);
    instr_valid = 1'b0; host_we = 1'b0;
    repeat (5) @(negedge clock);
    host_read(4'd13, r);
    n_tests++; if (r !== 16'h0222) begin n_fail++; $display("FAIL accept_with_we: got %h expected 0222", r); end
    run_instr(OP_ADD, 4'd14, 4'd14, 4'd14, lat, nd);
    host_read(4'd14, r);
    n_tests++; if (r !== 16'h2468) begin n_fail++; $display("FAIL alias_rw: got %h expected 2468", r); end
  endtask

  task automatic test_reset_mid;
    int nd; logic [15:0] r;
    @(negedge clock);
    instr = {OP_ADD, 4'd10, 4'd11, 4'd3};
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", instr_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", err); end
    @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done) nd++;
    end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d expected 0", nd); end
    host_read(4'd3, r);
    n_tests++; if (r !== 16'h0380) begin n_fail++; $display("FAIL rst_mid_dst: got %h expected 0380", r); end
  endtask

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    repeat (2) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    test_add;
    test_saturate;
    test_activation;
    test_sigmoid;
    test_back_to_back;
    test_host_we_busy;
    test_coincident_and_alias;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ae_exec_core.md
AE_EXEC_CORE -- requirements
Module: ae_exec_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width, signed fixed-point.
REQ-002 SHALL have parameter FRAC_W, default 8, fraction bits; range 1..DATA_W-2.
REQ-003 SHALL have parameter ADDR_W, default 4, memory address width; depth is 2^ADDR_W.
REQ-004 SHALL have parameter LUT_AW, default 6, sigmoid LUT address width.
REQ-005 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port instr_valid, input, 1, instruction offered.
REQ-008 SHALL have port instr_ready, output, 1, core accepts an instruction this cycle.
REQ-009 SHALL have port instr, input, 4+3*ADDR_W, fields {op[3:0], src_a, src_b, dst} from MSB down.
REQ-010 SHALL have port busy, output, 1, instruction in flight.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on writeback.
REQ-012 SHALL have port err, output, 1, sticky error flag.
REQ-013 SHALL have ports host_we (input, 1), host_addr (input, ADDR_W), host_wdata (input, DATA_W) and host_rdata (output, DATA_W), for memory load and readback.

Function
REQ-014 SHALL decode op[1:0] as the ALU op: 00 A+B, 01 A-B, 10 (A*B)>>>FRAC_W, 11 pass A.
REQ-015 SHALL decode op[3:2] as the activation: 00 none, 01 ReLU, 10 ReLU derivative, 11 sigmoid.
REQ-016 SHALL run the FSM IDLE->READ->EXEC->WRITE->IDLE; the IDLE->READ transition occurs only on instr_valid&&instr_ready.
REQ-017 SHALL drive instr_ready=(state==IDLE) and busy=!instr_ready.
REQ-018 SHALL register operands mem[src_a] and mem[src_b] in READ, register the ALU+activation result in EXEC, and write mem[dst] with done=1 in WRITE.
REQ-019 SHALL have a latency of exactly 3 cycles from the accept edge to done, with a throughput of one instruction per 4 cycles.
REQ-020 SHALL saturate add, sub and mul results to the signed DATA_W range, computing mul at 2*DATA_W width before shifting.
REQ-021 SHALL implement ReLU as x<0 -> 0, else x.
REQ-022 SHALL implement ReLU derivative as x>0 -> 1.0 (1<<FRAC_W), else 0.
REQ-023 SHALL implement sigmoid as: x<=-4.0 -> 0; x>=4.0 -> 1.0; otherwise a 2^LUT_AW-entry table spanning [-4.0,4.0), indexed by the truncated offset x+4.0.
REQ-024 SHALL perform host_we writes only in IDLE and drop them silently otherwise.
REQ-025 SHALL, when host_we and an accept coincide, perform the write and let READ see the new value.
REQ-026 SHALL register host_rdata as mem[host_addr] with 1-cycle latency in any state.
REQ-027 SHALL give a WRITE-stage write to the same address as a concurrent host read the new value one cycle later.
REQ-028 SHALL allow src_a==src_b==dst, with reads in READ preceding the write in WRITE.

Reset
REQ-029 SHALL, on reset_n low, immediately set state=IDLE, instr_ready=1, busy=0, done=0, err=0, host_rdata=0 and clear internal operand/result registers.
REQ-030 SHALL, on reset asserted mid-instruction, abort the instruction with no write to memory.
REQ-031 SHALL leave memory contents unspecified after reset (not cleared).

Configuration
REQ-032 SHALL, with macro AE_SIGMOID_EN defined, implement sigmoid per REQ-023.
REQ-033 SHALL, without AE_SIGMOID_EN, omit the LUT; an op[3:2]=11 instruction then writes the unactivated ALU result, sets err=1, and still pulses done.

Structure
REQ-034 SHALL place opcode and activation encodings, FSM state encodings and the 1.0 constant helper in shared package ae_pkg.
REQ-035 SHALL implement the activation stage as sub-module ae_act_unit (combinational, parametrised by DATA_W/FRAC_W/LUT_AW, containing the LUT).

Verification (DATA_W=16, FRAC_W=8)
REQ-036 SHALL verify: load mem[1]=0x0180 (1.5), mem[2]=0x0200 (2.0); op=0x0 a=1 b=2 d=3 -> done 3 cycles after accept; mem[3]=0x0380.
REQ-037 SHALL verify: mem[1]=0x7F00, mem[2]=0x7F00, op ADD -> 0x7FFF; op MUL 0x0180*0xFE00 (1.5*-2.0) -> 0xFD00.
REQ-038 SHALL verify: op SUB+ReLU with 0x0100-0x0300 -> 0x0000; op pass+ReLU' with 0x0001 -> 0x0100.
REQ-039 SHALL verify: sigmoid pass of 0x0000 -> 0x0080; of 0x0500 -> 0x0100; of 0xFB00 -> 0x0000; with the macro undefined, err=1 and the raw value is written.
REQ-040 SHALL verify: back-to-back instr_valid held high -> accepts exactly every 4 cycles; host_we while busy leaves memory unchanged.
REQ-041 SHALL verify: reset_n pulsed low during EXEC -> no done, destination unchanged, instr_ready=1 immediately.
